tx_signal_generator: RTL and testbench

Transmit-side counterpart of the receive chain. On a start request it generates one of 16 pseudo-random binary sequences and BPSK-modulates it onto a sampled carrier. It emits one signed 16-bit sample every SAMPLE_PERIOD clocks, which is the rate the receive low-pass/decimation front end consumes. It sits between the transmit controller, which issues the start and sequence ID, and the DAC interface. It also reports the transmit start timestamp used for ranging.

---
 rtl/tx_signal_generator.sv | 190 +++++++++++++++++++
 tb/tb_tx_signal_generator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_signal_generator.sv
// BPSK transmit generator: 8-bit LFSR chip sequence modulated onto an 8-point sampled carrier.
// Optional TX_TIMESTAMP_EN builds the free-running sample-tick counter behind otimestamp.
module tx_signal_generator #(
  parameter int unsigned SAMPLE_PERIOD = 128,
  parameter int unsigned CHIP_SAMPLES  = 8,
  parameter int unsigned SEQ_LEN       = 255,
  parameter int unsigned AMP           = 16384
) (
  input  logic               ctx_clk,
  input  logic               rtx_rst,
  input  logic               etx_en,
  input  logic               istart,
  input  logic [3:0]         iseq_id,
  output logic               obusy,
  output logic               osample_valid,
  output logic signed [15:0] osample,
  output logic               odone,
  output logic [31:0]        otimestamp
);

  localparam int unsigned TickW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned SampW = (CHIP_SAMPLES > 8) ? $clog2(CHIP_SAMPLES) : 3;

  localparam logic [TickW-1:0]   TickMax = TickW'(SAMPLE_PERIOD - 1);
  localparam logic [SampW-1:0]   SampMax = SampW'(CHIP_SAMPLES - 1);
  localparam logic [7:0]         ChipMax = 8'(SEQ_LEN - 1);
  localparam logic signed [15:0] LutAmp  = 16'(AMP);
  localparam logic signed [15:0] LutK    = 16'((AMP * 181) >> 8);

  if (SAMPLE_PERIOD < 2) begin : g_bad_period
    $error("SAMPLE_PERIOD must be at least 2");
  end
  if ((CHIP_SAMPLES == 0) || (CHIP_SAMPLES % 8 != 0)) begin : g_bad_chip
    $error("CHIP_SAMPLES must be a non-zero multiple of 8");
  end
  if ((SEQ_LEN < 1) || (SEQ_LEN > 255)) begin : g_bad_len
    $error("SEQ_LEN must be in 1..255");
  end
  if ((AMP < 1) || (AMP > 32767)) begin : g_bad_amp
    $error("AMP must be in 1..32767");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [SampW-1:0]   samp_q, samp_d;
  logic [7:0]         chip_q, chip_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic signed [15:0] sample_q, sample_d;

  logic               fb;
  logic signed [15:0] lut_val;

  assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Carrier phase follows the in-chip sample index; CHIP_SAMPLES is a multiple of 8,
  // so this equals the global sample index mod 8 and stays continuous across chips.
  always_comb begin
    lut_val = '0;
    unique case (samp_q[2:0])
      3'd0, 3'd4: lut_val = '0;
      3'd1, 3'd3: lut_val = LutK;
      3'd2:       lut_val = LutAmp;
      3'd5, 3'd7: lut_val = -LutK;
      3'd6:       lut_val = -LutAmp;
      default:    lut_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    samp_d   = samp_q;
    chip_d   = chip_q;
    lfsr_d   = lfsr_q;
    busy_d   = busy_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d   = 1'b0;
        sample_d = '0;
        if (istart && etx_en) begin
          state_d = StRun;
          busy_d  = 1'b1;
          lfsr_d  = {iseq_id, ~iseq_id};
          tick_d  = '0;
          samp_d  = '0;
          chip_d  = '0;
        end
      end
      StRun: begin
        if (!etx_en) begin
          state_d  = StIdle;
          busy_d   = 1'b0;
          sample_d = '0;
        end else begin
          tick_d = (tick_q == TickMax) ? '0 : tick_q + TickW'(1);
          // A tick count of zero marks a sample slot; the first one lands right after the start.
          if (tick_q == '0) begin
            valid_d  = 1'b1;
            sample_d = lfsr_q[0] ? lut_val : -lut_val;
            if (samp_q == SampMax) begin
              samp_d = '0;
              lfsr_d = {fb, lfsr_q[7:1]};
              chip_d = chip_q + 8'd1;
              // Busy and the held sample clear on the following edge, in StIdle.
              if (chip_q == ChipMax) begin
                done_d  = 1'b1;
                state_d = StIdle;
              end
            end else begin
              samp_d = samp_q + SampW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ctx_clk or negedge rtx_rst) begin
    if (!rtx_rst) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      samp_q   <= '0;
      chip_q   <= '0;
      lfsr_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      samp_q   <= samp_d;
      chip_q   <= chip_d;
      lfsr_q   <= lfsr_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      sample_q <= sample_d;
    end
  end

  assign obusy         = busy_q;
  assign osample_valid = valid_q;
  assign osample       = sample_q;
  assign odone         = done_q;

`ifdef TX_TIMESTAMP_EN
  logic [TickW-1:0] pre_q, pre_d;
  logic [31:0]      ts_q, ts_d;
  logic [31:0]      ts_lat_q, ts_lat_d;
  logic             first_strobe;

  assign first_strobe = (state_q == StRun) && etx_en && (tick_q == '0) &&
                        (samp_q == '0) && (chip_q == '0);

  // Free-running from reset, independent of the transmit FSM; wraps naturally at 2^32.
  always_comb begin
    pre_d    = (pre_q == TickMax) ? '0 : pre_q + TickW'(1);
    ts_d     = (pre_q == TickMax) ? ts_q + 32'd1 : ts_q;
    ts_lat_d = first_strobe ? ts_q : ts_lat_q;
  end

  always_ff @(posedge ctx_clk or negedge rtx_rst) begin
    if (!rtx_rst) begin
      pre_q    <= '0;
      ts_q     <= '0;
      ts_lat_q <= '0;
    end else begin
      pre_q    <= pre_d;
      ts_q     <= ts_d;
      ts_lat_q <= ts_lat_d;
    end
  end

  assign otimestamp = ts_lat_q;
`else
  assign otimestamp = '0;
`endif

endmodule

// File: tb/tb_tx_signal_generator.sv
// Directed bench for tx_signal_generator with a short sample period to keep runs brief.
// Expected carrier values are hand-computed for AMP=16384 (K=11584).
module tb_tx_signal_generator;

  localparam int unsigned P    = 4;
  localparam int unsigned CS   = 8;
  localparam int unsigned SL   = 255;
  localparam int unsigned AMP  = 16384;
  localparam int          NTOT = 2040;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         id = 4'd0;
  logic               busy;
  logic               valid;
  logic signed [15:0] sample;
  logic               done;
  logic [31:0]        ts;

  int n_cmp = 0;
  int n_bad = 0;
  int edges;

  int exp_pos[8] = '{0, 11584, 16384, 11584, 0, -11584, -16384, -11584};

  tx_signal_generator #(
    .SAMPLE_PERIOD(P),
    .CHIP_SAMPLES (CS),
    .SEQ_LEN      (SL),
    .AMP          (AMP)
  ) dut (
    .ctx_clk      (clk),
    .rtx_rst      (rst_n),
    .etx_en       (en),
    .istart       (start),
    .iseq_id      (id),
    .obusy        (busy),
    .osample_valid(valid),
    .osample      (sample),
    .odone        (done),
    .otimestamp   (ts)
  );

  always #5 clk = ~clk;

  // Count of rising edges since reset release, used as the timestamp reference.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[7] ^ l[5] ^ l[4] ^ l[3], l[7:1]};
  endfunction

  task automatic start_tx(input logic [3:0] sid);
    @(negedge clk);
    start = 1'b1;
    id    = sid;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_novalid", valid, 0);
    check_eq("start_sample0", sample, 0);
  endtask

  // Follows one transmission already accepted; hand_sign is the chip polarity of chips 0 and 1.
  task automatic run_tx(input string tag, input logic [3:0] sid, input int hand_sign,
                        input int abort_at, input int poke_at, input bit chain,
                        input logic [3:0] chain_id);
    logic [7:0] m;
    int s, strobes, dones, done_last, since, gap_min, gap_max, first_lat, bad_model, cyc;
    int expv, quiet;
    bit fin;
    m = {sid, ~sid};
    s = 0; strobes = 0; dones = 0; done_last = 0; since = 0; cyc = 0;
    gap_min = 1000000; gap_max = 0; first_lat = -1; bad_model = 0; fin = 1'b0;
    while (!fin && cyc < NTOT * P + 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      since++;
      if (valid) begin
        if (strobes == 0) begin
          first_lat = cyc;
`ifdef TX_TIMESTAMP_EN
          check_eq({tag, "_ts"}, ts, (edges - 1) / P);
`else
          check_eq({tag, "_ts0"}, ts, 0);
`endif
        end else begin
          if (since < gap_min) gap_min = since;
          if (since > gap_max) gap_max = since;
        end
        since = 0;
        if (strobes < 16) begin
          check_eq($sformatf("%s_s%0d", tag, strobes), sample, hand_sign * exp_pos[strobes % 8]);
        end else begin
          expv = m[0] ? exp_pos[s] : -exp_pos[s];
          if (sample !== 16'(expv)) bad_model++;
        end
        if (done) begin
          dones++;
          if (strobes == NTOT - 1) done_last = 1;
        end
        strobes++;
        s++;
        if (s == CS) begin
          s = 0;
          m = lfsr_next(m);
        end
        if (strobes == poke_at) begin
          start = 1'b1;
          id    = sid ^ 4'h5;
        end
        if (strobes == abort_at) begin
          en = 1'b0;
          @(negedge clk);
          check_eq({tag, "_abort_busy"}, busy, 0);
          check_eq({tag, "_abort_sample"}, sample, 0);
          quiet = 0;
          repeat (3 * P) begin
            @(negedge clk);
            if (valid || done || busy) quiet++;
          end
          check_eq({tag, "_abort_quiet"}, quiet, 0);
          en  = 1'b1;
          fin = 1'b1;
        end else if (done) begin
          fin = 1'b1;
          if (chain) begin
            start = 1'b1;
            id    = chain_id;
          end
          @(negedge clk);
          start = 1'b0;
          check_eq({tag, "_after_busy"}, busy, chain ? 1 : 0);
          check_eq({tag, "_after_sample"}, sample, 0);
          check_eq({tag, "_after_valid"}, valid, 0);
        end
      end else if (done) begin
        dones++;
      end
    end
    check_eq({tag, "_finished"}, fin, 1);
    check_eq({tag, "_first_latency"}, first_lat, 1);
    if (abort_at > 0) begin
      check_eq({tag, "_strobes"}, strobes, abort_at);
      check_eq({tag, "_dones"}, dones, 0);
    end else begin
      check_eq({tag, "_strobes"}, strobes, NTOT);
      check_eq({tag, "_dones"}, dones, 1);
      check_eq({tag, "_done_last"}, done_last, 1);
      check_eq({tag, "_model"}, bad_model, 0);
      check_eq({tag, "_gap_min"}, gap_min, P);
      check_eq({tag, "_gap_max"}, gap_max, P);
    end
  endtask

  initial begin
    int anom, seen;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ts", ts, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    anom = 0;
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (valid) seen++;
      if (busy || done || sample != 0) anom++;
    end
    check_eq("idle_strobes", seen, 0);
    check_eq("idle_quiet", anom, 0);

    en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("disabled_start", busy, 0);
    en = 1'b1;

    // Fresh reset so the timestamp start lands at a known edge (10*P+5).
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    while (edges < 10 * P + 4) @(negedge clk);
    start_tx(4'd0);
    run_tx("seq0", 4'd0, 1, 0, 0, 1'b1, 4'd15);
    run_tx("seq15", 4'd15, -1, 0, 100, 1'b0, 4'd0);

    start_tx(4'd7);
    run_tx("abort7", 4'd7, -1, 500, 0, 1'b0, 4'd0);
    start_tx(4'd7);
    run_tx("again7", 4'd7, -1, 0, 0, 1'b0, 4'd0);

    start_tx(4'd3);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_busy", busy, 0);
    check_eq("async_sample", sample, 0);
    check_eq("async_valid", valid, 0);
    check_eq("async_ts", ts, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
